// File: rtl/ffstdp_pkg.sv
// Shared types and constants for the FF-STDP synaptic sweep sequencer.
// Holds the sweep state encoding and the read-to-write pipeline distance.
package ffstdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // Cycles from SRAM read issue to the matching weight/gradient write-back.
  localparam int FFSTDP_UPD_LAT = 2;

endpackage

// File: rtl/ffstdp_idx_counter.sv
// Nested (pre, post) synapse index counter: post is the inner loop and pre the
// outer loop; 'last' flags that the counter sits on (N_PRE-1, N_POST-1).
module ffstdp_idx_counter #(
  parameter int N_PRE          = 256,
  parameter int N_POST         = 256,
  parameter int PRE_IDX_WIDTH  = 8,
  parameter int POST_IDX_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [PRE_IDX_WIDTH-1:0]  pre_idx,
  output logic [POST_IDX_WIDTH-1:0] post_idx,
  output logic                      last
);

  localparam logic [PRE_IDX_WIDTH-1:0]  PRE_MAX  = PRE_IDX_WIDTH'(N_PRE - 1);
  localparam logic [POST_IDX_WIDTH-1:0] POST_MAX = POST_IDX_WIDTH'(N_POST - 1);

  logic [PRE_IDX_WIDTH-1:0]  pre_q, pre_d;
  logic [POST_IDX_WIDTH-1:0] post_q, post_d;
  logic                      pre_last, post_last;

  assign pre_last  = (pre_q == PRE_MAX);
  assign post_last = (post_q == POST_MAX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pre_d  = pre_q;
    post_d = post_q;
    if (clr) begin
      pre_d  = '0;
      post_d = '0;
    end else if (inc) begin
      if (post_last) begin
        post_d = '0;
        pre_d  = pre_last ? '0 : pre_q + PRE_IDX_WIDTH'(1);
      end else begin
        post_d = post_q + POST_IDX_WIDTH'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      post_q <= '0;
    end else begin
      pre_q  <= pre_d;
      post_q <= post_d;
    end
  end

  assign pre_idx  = pre_q;
  assign post_idx = post_q;
  assign last     = pre_last && post_last;

endmodule

// File: rtl/ffstdp_sweep_ctrl.sv
// FF-STDP sweep sequencer: walks every (pre, post) synapse once per START,
// issuing SRAM reads, count-memory lookups, update strobes and write-backs.
// Optional FFSTDP_SWEEP_PAUSE_EN adds a PAUSE input that inserts read bubbles.
module ffstdp_sweep_ctrl
  import ffstdp_pkg::*;
#(
  parameter int N_PRE          = 256,
  parameter int N_POST         = 256,
  parameter int PRE_IDX_WIDTH  = 8,
  parameter int POST_IDX_WIDTH = 8,
  parameter int SYN_ADDR_WIDTH = PRE_IDX_WIDTH + POST_IDX_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic                      IS_POS,
  input  logic                      IS_TRAIN,
`ifdef FFSTDP_SWEEP_PAUSE_EN
  input  logic                      PAUSE,
`endif
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      SRAM_RD_EN,
  output logic [SYN_ADDR_WIDTH-1:0] SRAM_RD_ADDR,
  output logic                      SRAM_WR_EN,
  output logic [SYN_ADDR_WIDTH-1:0] SRAM_WR_ADDR,
  output logic [PRE_IDX_WIDTH-1:0]  CNT_PRE_IDX,
  output logic [POST_IDX_WIDTH-1:0] CNT_POST_IDX,
  output logic                      UPD_EVENT,
  output logic                      UPD_IS_POS,
  output logic                      UPD_IS_TRAIN
);

  localparam int LAT = FFSTDP_UPD_LAT;

  sweep_state_e state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rd_en_q, rd_en_d;
  logic         is_pos_q, is_pos_d;
  logic         is_train_q, is_train_d;

  // Stage 2..LAT+1 of the valid/address shift register; stage 1 is rd_en_q + counter.
  logic [LAT-1:0]                     vld_q, vld_d;
  logic [LAT-1:0][SYN_ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                      pause_w;
  logic                      cnt_clr, cnt_inc, cnt_last;
  logic [PRE_IDX_WIDTH-1:0]  pre_idx;
  logic [POST_IDX_WIDTH-1:0] post_idx;
  logic [SYN_ADDR_WIDTH-1:0] rd_addr;
  logic                      pipe_busy;

`ifdef FFSTDP_SWEEP_PAUSE_EN
  assign pause_w = PAUSE;
`else
  assign pause_w = 1'b0;
`endif

  // The counter holds the address of the read presented this cycle.
  ffstdp_idx_counter #(
    .N_PRE         (N_PRE),
    .N_POST        (N_POST),
    .PRE_IDX_WIDTH (PRE_IDX_WIDTH),
    .POST_IDX_WIDTH(POST_IDX_WIDTH)
  ) u_idx_counter (
    .clk     (CLK),
    .rst     (RST),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .pre_idx (pre_idx),
    .post_idx(post_idx),
    .last    (cnt_last)
  );

  assign rd_addr = SYN_ADDR_WIDTH'({pre_idx, post_idx});

  always_comb begin
    vld_d     = {vld_q[LAT-2:0], rd_en_q};
    addr_d    = addr_q;
    addr_d[0] = rd_addr;
    for (int i = 1; i < LAT; i++) addr_d[i] = addr_q[i-1];
    pipe_busy = rd_en_q;
    for (int i = 0; i < LAT - 1; i++) pipe_busy = pipe_busy | vld_q[i];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    is_pos_d   = is_pos_q;
    is_train_d = is_train_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          is_pos_d   = IS_POS;
          is_train_d = IS_TRAIN;
          cnt_clr    = 1'b1;
          rd_en_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        // Reaching the terminal index means the final read is already out.
        if (cnt_last) begin
          state_d = ST_DRAIN;
        end else if (!pause_w) begin
          cnt_inc = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline registers are reset too: they drive outputs that must read 0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      is_pos_q   <= 1'b0;
      is_train_q <= 1'b0;
      vld_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      is_pos_q   <= is_pos_d;
      is_train_q <= is_train_d;
      vld_q      <= vld_d;
      addr_q     <= addr_d;
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign SRAM_RD_EN   = rd_en_q;
  assign SRAM_RD_ADDR = rd_addr;
  assign CNT_PRE_IDX  = addr_q[0][POST_IDX_WIDTH +: PRE_IDX_WIDTH];
  assign CNT_POST_IDX = addr_q[0][POST_IDX_WIDTH-1:0];
  assign SRAM_WR_EN   = vld_q[LAT-1];
  assign SRAM_WR_ADDR = addr_q[LAT-1];
  assign UPD_EVENT    = vld_q[LAT-1];
  assign UPD_IS_POS   = is_pos_q;
  assign UPD_IS_TRAIN = is_train_q;

endmodule

// File: tb/tb_ffstdp_sweep_ctrl.sv
// Scoreboard bench for ffstdp_sweep_ctrl: a 2x3 sweep instance and a 1x1 instance;
// expected reads, count lookups, writes and DONE pulses are queued with their cycle.
module tb_ffstdp_sweep_ctrl;

  typedef struct {
    int id;
    int kind;  // 0 read, 1 write, 2 done, 3 count-index lookup
    int cyc;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];
  int   busy_lo[2];
  int   busy_hi[2];
  logic exp_pos[2];
  logic exp_train[2];

  logic start_0, pos_0, train_0, pause_0;
  logic start_1, pos_1, train_1;
  logic busy_0, done_0, rd_en_0, wr_en_0, ev_0, upos_0, utrain_0;
  logic busy_1, done_1, rd_en_1, wr_en_1, ev_1, upos_1, utrain_1;
  logic [15:0] rd_addr_0, wr_addr_0, rd_addr_1, wr_addr_1;
  logic [7:0]  cpre_0, cpost_0, cpre_1, cpost_1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ffstdp_sweep_ctrl #(.N_PRE(2), .N_POST(3)) dut0 (
    .CLK(clk), .RST(rst), .START(start_0), .IS_POS(pos_0), .IS_TRAIN(train_0),
`ifdef FFSTDP_SWEEP_PAUSE_EN
    .PAUSE(pause_0),
`endif
    .BUSY(busy_0), .DONE(done_0), .SRAM_RD_EN(rd_en_0), .SRAM_RD_ADDR(rd_addr_0),
    .SRAM_WR_EN(wr_en_0), .SRAM_WR_ADDR(wr_addr_0), .CNT_PRE_IDX(cpre_0),
    .CNT_POST_IDX(cpost_0), .UPD_EVENT(ev_0), .UPD_IS_POS(upos_0), .UPD_IS_TRAIN(utrain_0)
  );

  ffstdp_sweep_ctrl #(.N_PRE(1), .N_POST(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start_1), .IS_POS(pos_1), .IS_TRAIN(train_1),
`ifdef FFSTDP_SWEEP_PAUSE_EN
    .PAUSE(1'b0),
`endif
    .BUSY(busy_1), .DONE(done_1), .SRAM_RD_EN(rd_en_1), .SRAM_RD_ADDR(rd_addr_1),
    .SRAM_WR_EN(wr_en_1), .SRAM_WR_ADDR(wr_addr_1), .CNT_PRE_IDX(cpre_1),
    .CNT_POST_IDX(cpost_1), .UPD_EVENT(ev_1), .UPD_IS_POS(upos_1), .UPD_IS_TRAIN(utrain_1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_one(input int id, input int kind, input int c, input int a);
    exp_t e;
    e.id = id; e.kind = kind; e.cyc = c; e.addr = a;
    sb.push_back(e);
  endtask

  // Full sweep started in cycle 'base'; reads with index >= gap_after slip by gap_len.
  task automatic push_sweep(input int id, input int base, input int n_pre, input int n_post,
                            input logic pos, input logic train,
                            input int gap_after, input int gap_len);
    int n, k, t;
    n = n_pre * n_post;
    for (int p = 0; p < n_pre; p++) begin
      for (int q = 0; q < n_post; q++) begin
        k = p * n_post + q;
        t = base + 1 + k + ((k >= gap_after) ? gap_len : 0);
        push_one(id, 0, t, p * 256 + q);
        push_one(id, 3, t + 1, p * 256 + q);
        push_one(id, 1, t + 2, p * 256 + q);
      end
    end
    push_one(id, 2, base + n + 3 + gap_len, 0);
    busy_lo[id]   = base + 1;
    busy_hi[id]   = base + n + 2 + gap_len;
    exp_pos[id]   = pos;
    exp_train[id] = train;
  endtask

  task automatic pop_cmp(input int id, input int kind, input logic [31:0] addr, input string nm);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].id == id && sb[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      check({nm, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      check({nm, "_cyc"}, cyc, sb[idx].cyc);
      check({nm, "_addr"}, addr, sb[idx].addr);
      sb.delete(idx);
    end
  endtask

  task automatic mon(input int id, input logic busy, input logic done, input logic rd,
                     input logic [15:0] ra, input logic wr, input logic [15:0] wa,
                     input logic [15:0] cidx, input logic ev, input logic upos,
                     input logic utrain);
    string pfx;
    pfx = $sformatf("d%0d_", id);
    if (rd) pop_cmp(id, 0, {16'd0, ra}, {pfx, "rd"});
    if (wr) pop_cmp(id, 1, {16'd0, wa}, {pfx, "wr"});
    if (done) pop_cmp(id, 2, 32'd0, {pfx, "done"});
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].id == id && sb[i].kind == 3 && sb[i].cyc == cyc) begin
        check({pfx, "cnt_idx"}, {16'd0, cidx}, sb[i].addr);
        sb.delete(i);
        break;
      end
    end
    check({pfx, "upd_event"}, {31'd0, ev}, {31'd0, wr});
    check({pfx, "busy"}, {31'd0, busy}, (cyc >= busy_lo[id] && cyc <= busy_hi[id]) ? 1 : 0);
    if (busy) begin
      check({pfx, "upd_is_pos"}, {31'd0, upos}, {31'd0, exp_pos[id]});
      check({pfx, "upd_is_train"}, {31'd0, utrain}, {31'd0, exp_train[id]});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, busy_0, done_0, rd_en_0, rd_addr_0, wr_en_0, wr_addr_0, {cpre_0, cpost_0},
          ev_0, upos_0, utrain_0);
      mon(1, busy_1, done_1, rd_en_1, rd_addr_1, wr_en_1, wr_addr_1, {cpre_1, cpost_1},
          ev_1, upos_1, utrain_1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending(input int id);
    int n;
    n = 0;
    foreach (sb[i]) if (sb[i].id == id) n++;
    return n;
  endfunction

  task automatic wait_idle(input int id);
    int budget;
    budget = 60;
    while (pending(id) != 0 && budget > 0) begin
      tick();
      budget--;
    end
    repeat (3) tick();
    check($sformatf("d%0d_drain", id), pending(id), 32'd0);
  endtask

  function automatic logic [31:0] outs0();
    return {busy_0, done_0, rd_en_0, wr_en_0, ev_0, upos_0, utrain_0,
            rd_addr_0 | wr_addr_0, cpre_0 | cpost_0};
  endfunction

  int base;

  initial begin
    rst = 1'b1;
    start_0 = 0; pos_0 = 0; train_0 = 0; pause_0 = 0;
    start_1 = 0; pos_1 = 0; train_1 = 0;
    for (int i = 0; i < 2; i++) begin
      busy_lo[i] = -1; busy_hi[i] = -1; exp_pos[i] = 0; exp_train[i] = 0;
    end
    repeat (2) tick();
    check("reset_outs_d0", outs0(), 32'd0);
    check("reset_outs_d1", {busy_1, done_1, rd_en_1, wr_en_1, ev_1, upos_1, utrain_1,
                            rd_addr_1 | wr_addr_1, cpre_1 | cpost_1}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Plain 2x3 sweep.
    base = cyc;
    start_0 = 1; pos_0 = 0; train_0 = 1;
    push_sweep(0, base, 2, 3, 1'b0, 1'b1, 0, 0);
    tick();
    start_0 = 0;
    wait_idle(0);

    // START held 5 cycles, re-pulsed mid-sweep, modes toggled after acceptance.
    base = cyc;
    start_0 = 1; pos_0 = 1; train_0 = 0;
    push_sweep(0, base, 2, 3, 1'b1, 1'b0, 0, 0);
    tick(); pos_0 = 0; train_0 = 1;
    tick();
    tick(); pos_0 = 1; train_0 = 0;
    tick();
    tick(); start_0 = 0; pos_0 = 0; train_0 = 1;
    tick(); start_0 = 1;
    tick(); start_0 = 0;
    wait_idle(0);

`ifdef FFSTDP_SWEEP_PAUSE_EN
    // PAUSE seen at the edges into c2 and c3 -> read bubbles in c2..c3.
    base = cyc;
    start_0 = 1; pos_0 = 0; train_0 = 0;
    push_sweep(0, base, 2, 3, 1'b0, 1'b0, 1, 2);
    tick(); start_0 = 0; pause_0 = 1;
    tick();
    tick(); pause_0 = 0;
    wait_idle(0);
`endif

    // Reset in c4 mid-sweep, restart at c6 from address 0.
    base = cyc;
    start_0 = 1; pos_0 = 1; train_0 = 1;
    push_one(0, 0, base + 1, 0);   push_one(0, 0, base + 2, 1);
    push_one(0, 0, base + 3, 2);   push_one(0, 0, base + 4, 256);
    push_one(0, 3, base + 2, 0);   push_one(0, 3, base + 3, 1);
    push_one(0, 3, base + 4, 2);
    push_one(0, 1, base + 3, 0);   push_one(0, 1, base + 4, 1);
    busy_lo[0] = base + 1; busy_hi[0] = base + 4;
    exp_pos[0] = 1; exp_train[0] = 1;
    tick(); start_0 = 0;
    tick(); tick(); tick();
    rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    check("rst_mid_outs", outs0(), 32'd0);
    check("rst_mid_pending", pending(0), 32'd0);
    tick();
    base = cyc;
    start_0 = 1; pos_0 = 0; train_0 = 0;
    push_sweep(0, base, 2, 3, 1'b0, 1'b0, 0, 0);
    tick(); start_0 = 0;
    wait_idle(0);

    // Single-synapse core.
    base = cyc;
    start_1 = 1; pos_1 = 1; train_1 = 1;
    push_sweep(1, base, 1, 1, 1'b1, 1'b1, 0, 0);
    tick(); start_1 = 0;
    wait_idle(1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ffstdp_sweep_ctrl.md
# ffstdp_sweep_ctrl

Sequencer for the FF-STDP synaptic update datapath. On a start pulse it sweeps every (pre, post) synapse of the core: it issues synaptic SRAM reads, steers spike-count lookups, asserts the datapath update strobe, and writes the updated weight/gradient back. The SRAM is simple dual-port, so the sweep is fully pipelined at one synapse per cycle. It sits between the core epoch controller and the `ffstdp_update` datapath plus the synaptic SRAM.

## Interface
Parameters:
- `N_PRE`, 256, number of presynaptic inputs (≥1)
- `N_POST`, 256, number of postsynaptic neurons (≥1)
- `PRE_IDX_WIDTH`, 8, width of pre index (2^W ≥ N_PRE)
- `POST_IDX_WIDTH`, 8, width of post index (2^W ≥ N_POST)
- `SYN_ADDR_WIDTH`, PRE_IDX_WIDTH+POST_IDX_WIDTH, SRAM address width

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock
- `RST` in 1: synchronous active-high reset
- `START` in 1: one-cycle sweep request
- `IS_POS` in 1: sample polarity, latched at accepted START
- `IS_TRAIN` in 1: train (weight apply) vs accumulate, latched at accepted START
- `PAUSE` in 1: hold off new reads (only with `FFSTDP_SWEEP_PAUSE_EN`)
- `BUSY` out 1: sweep in progress
- `DONE` out 1: one-cycle pulse after last write
- `SRAM_RD_EN` out 1, `SRAM_RD_ADDR` out SYN_ADDR_WIDTH: read port
- `SRAM_WR_EN` out 1, `SRAM_WR_ADDR` out SYN_ADDR_WIDTH: write port (data = datapath WSYN_NEW/GRAD_NEW)
- `CNT_PRE_IDX` out PRE_IDX_WIDTH, `CNT_POST_IDX` out POST_IDX_WIDTH: spike-count memory read indices
- `UPD_EVENT` out 1: drives datapath CTRL_TREF_EVENT
- `UPD_IS_POS` out 1, `UPD_IS_TRAIN` out 1: latched modes to datapath

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: START=1 → latch IS_POS/IS_TRAIN, clear pre/post counters, → SWEEP. START ignored in every other state.
- SWEEP: each non-paused cycle, issue read at `{pre_idx, post_idx}`; post_idx is the inner loop (0..N_POST-1, wrap to 0 and increment pre_idx). After issuing (N_PRE-1, N_POST-1) → DRAIN.
- Pipeline: 3-stage valid/address shift register. Stage 1 = read issue; stage 2 = CNT_*_IDX driven (count memories are 1-cycle sync read); stage 3 = UPD_EVENT=1, SRAM_WR_EN=1, SRAM_WR_ADDR = stage-3 address.
- DRAIN: no reads; wait until the pipeline is empty → DONE. DONE lasts 1 cycle, pulses `DONE`, → IDLE.
- Pipeline stages advance unconditionally; PAUSE only inserts bubbles at stage 1 (bubbles give RD_EN=0 and, 2 cycles later, WR_EN=UPD_EVENT=0).
- Read and write addresses never coincide in one cycle (strictly increasing sweep).
- Reset (any state, incl. mid-sweep): → IDLE, pipeline cleared. SRAM rows already written stay written; no rollback.
- Reset values: all outputs 0.

## Timing
- c0: START high. c1: RD_EN=1, RD_ADDR=0, BUSY=1. c2: CNT_PRE_IDX/CNT_POST_IDX for address 0. c3: WR_EN=1, UPD_EVENT=1, WR_ADDR=0.
- With N = N_PRE·N_POST and no pauses: last read c(N), last write c(N+2), BUSY high c1..c(N+2), DONE=1 at c(N+3), BUSY=0 at c(N+3).
- Each PAUSE cycle during SWEEP extends all of the above by 1.
- All outputs are registered.

## Configuration
- `FFSTDP_SWEEP_PAUSE_EN` defined: the PAUSE port exists and behaves as above.
- Not defined: the PAUSE port is absent and is treated as 0. The sweep always takes exactly N+3 cycles from START to DONE.

## Structure
- Shared package `ffstdp_pkg`: the state enum (IDLE/SWEEP/DRAIN/DONE) and the pipeline depth constant (`FFSTDP_UPD_LAT = 2`, read-to-write distance).
- Natural sub-module `ffstdp_idx_counter`: the nested pre/post counter with terminal-count flag. The rest is flat.

## Test plan
- N_PRE=2, N_POST=3, START at c0 → reads at addresses 0,1,2,256,257,258 in c1..c6; writes at the same addresses in c3..c8; DONE at c9 only.
- START held high for 5 cycles and pulsed again mid-sweep → exactly one sweep, DONE once, second request ignored.
- IS_POS=1, IS_TRAIN=0 at START, then both toggled during the sweep → UPD_IS_POS=1, UPD_IS_TRAIN=0 for the whole sweep.
- (PAUSE_EN) PAUSE high c2–c3 → RD_EN=0 in c2–c3; WR_EN=0 in c4–c5; DONE at c11; address order unchanged.
- RST at c4 mid-sweep → c5 all outputs 0, BUSY=0; a new START at c6 restarts from address 0.
- N_PRE=1, N_POST=1 → a single read at c1, a single write at c3, DONE at c4.
